// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard sequencer.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 32;

    typedef enum logic [1:0] {
        RUN,
        PEND,
        WFI
    } hz_state_t;

    // True when the ID instruction really reads the register the EXE load writes.
    // x0 is never a hazard.
    function automatic logic load_use_match(
        input logic                  load,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic                  use_rs1,
        input logic                  use_rs2
    );
        return load && (rd != '0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/event_counter.sv
// Free-running wrapping event counter with count enable.
module event_counter
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count one per enabled cycle; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: merges memory stalls, load-use, redirects and WFI sleep,
// replays redirects raised during a stall, and counts stall/flush cycles.
module pipe_hazard_ctrl
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Istall,
    input  logic                  Dstall,
    input  logic                  load_EXE,
    input  logic [REG_ADDR_W-1:0] write_addr_EXE,
    input  logic [REG_ADDR_W-1:0] Read_addr_1_ID,
    input  logic [REG_ADDR_W-1:0] Read_addr_2_ID,
    input  logic                  use_rs1_ID,
    input  logic                  use_rs2_ID,
    input  logic                  branch_taken_EXE,
    input  logic                  jalr_EXE,
    input  logic                  wfi_EXE,
    input  logic                  irq_pending,
    output logic                  pc_hold,
    output logic                  ifid_hold,
    output logic                  mem_stall,
    output logic                  wfi_stall,
    output logic                  flush,
    output logic                  flush_jalr,
    output logic                  idexe_bubble,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    hz_state_t state_q, state_d;
    logic      pb_q, pb_d;
    logic      pj_q, pj_d;
    logic      ms, lu, redir;
    logic      lu_hold;

    assign ms    = Istall | Dstall;
    assign redir = branch_taken_EXE | jalr_EXE;
    assign lu    = load_use_match(load_EXE, write_addr_EXE, Read_addr_1_ID,
                                  Read_addr_2_ID, use_rs1_ID, use_rs2_ID);

    // State and pending-redirect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pb_q    <= 1'b0;
            pj_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pb_q    <= pb_d;
            pj_q    <= pj_d;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_d      = state_q;
        pb_d         = pb_q;
        pj_d         = pj_q;
        flush        = 1'b0;
        flush_jalr   = 1'b0;
        idexe_bubble = 1'b0;
        wfi_stall    = 1'b0;
        lu_hold      = 1'b0;
        unique case (state_q)
            RUN: begin
                if (!ms) begin
                    flush      = branch_taken_EXE;
                    flush_jalr = jalr_EXE;
                end
                if (lu && !redir) begin
                    lu_hold      = 1'b1;
                    idexe_bubble = 1'b1;
                end
                if (ms && redir) begin
                    pb_d    = branch_taken_EXE;
                    pj_d    = jalr_EXE;
                    state_d = PEND;
                end else if (wfi_EXE && !ms && !redir && !irq_pending) begin
                    state_d = WFI;
                end
            end
            PEND: begin
                if (ms) begin
                    pb_d = pb_q | branch_taken_EXE;
                    pj_d = pj_q | jalr_EXE;
                end else begin
                    // The EXE instruction was held, so a redirect still raised now
                    // is the same one already latched; ORing it costs nothing.
                    flush      = pb_q | branch_taken_EXE;
                    flush_jalr = pj_q | jalr_EXE;
                    pb_d       = 1'b0;
                    pj_d       = 1'b0;
                    state_d    = RUN;
                end
            end
            WFI: begin
                wfi_stall = ~irq_pending;
                if (irq_pending) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign mem_stall = ms;
    assign pc_hold   = ms | lu_hold | wfi_stall;
    assign ifid_hold = pc_hold;

    event_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (pc_hold),
        .count (stall_cnt)
    );

    event_counter u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush | flush_jalr),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Istall = 1'b0, Dstall = 1'b0, load_EXE = 1'b0;
    logic [4:0]  write_addr_EXE = '0, Read_addr_1_ID = '0, Read_addr_2_ID = '0;
    logic        use_rs1_ID = 1'b0, use_rs2_ID = 1'b0;
    logic        branch_taken_EXE = 1'b0, jalr_EXE = 1'b0;
    logic        wfi_EXE = 1'b0, irq_pending = 1'b0;
    logic        pc_hold, ifid_hold, mem_stall, wfi_stall, flush, flush_jalr, idexe_bubble;
    logic [31:0] stall_cnt, flush_cnt;

    typedef struct {
        int          idx;
        logic [6:0]  outs;
        logic        chk_cnt;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_vec = 0;
    logic drv_done = 1'b0;

    // outs = {pc_hold, ifid_hold, mem_stall, wfi_stall, flush, flush_jalr, idexe_bubble}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_MEM  = 7'b1110000;
    localparam logic [6:0] O_LU   = 7'b1100001;
    localparam logic [6:0] O_BR   = 7'b0000100;
    localparam logic [6:0] O_JR   = 7'b0000010;
    localparam logic [6:0] O_BOTH = 7'b0000110;
    localparam logic [6:0] O_WFI  = 7'b1101000;

    pipe_hazard_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .Istall           (Istall),
        .Dstall           (Dstall),
        .load_EXE         (load_EXE),
        .write_addr_EXE   (write_addr_EXE),
        .Read_addr_1_ID   (Read_addr_1_ID),
        .Read_addr_2_ID   (Read_addr_2_ID),
        .use_rs1_ID       (use_rs1_ID),
        .use_rs2_ID       (use_rs2_ID),
        .branch_taken_EXE (branch_taken_EXE),
        .jalr_EXE         (jalr_EXE),
        .wfi_EXE          (wfi_EXE),
        .irq_pending      (irq_pending),
        .pc_hold          (pc_hold),
        .ifid_hold        (ifid_hold),
        .mem_stall        (mem_stall),
        .wfi_stall        (wfi_stall),
        .flush            (flush),
        .flush_jalr       (flush_jalr),
        .idexe_bubble     (idexe_bubble),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus: drive just after the rising edge, push the expectation.
    task automatic step(input logic r, input logic [1:0] mem, input logic ld,
                        input logic [4:0] wa, input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic [1:0] uses, input logic [1:0] rd, input logic [1:0] wq,
                        input logic [6:0] eo, input logic ck, input logic [31:0] sc,
                        input logic [31:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        {Istall, Dstall} = mem;
        load_EXE         = ld;
        write_addr_EXE   = wa;
        Read_addr_1_ID   = ra1;
        Read_addr_2_ID   = ra2;
        {use_rs1_ID, use_rs2_ID}     = uses;
        {branch_taken_EXE, jalr_EXE} = rd;
        {wfi_EXE, irq_pending}       = wq;
        e.idx = n_vec; e.outs = eo; e.chk_cnt = ck; e.scnt = sc; e.fcnt = fc;
        exp_q.push_back(e);
        n_vec++;
    endtask

    // Driver: directed vectors with hand-computed expectations.
    initial begin
        // reset state
        step(1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_NONE, 1, 0, 0);      // 0
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_NONE, 1, 0, 0);      // 1
        // load-use on rs1: one bubble cycle
        step(0, 2'b00, 1, 5, 5, 0, 2'b10, 2'b00, 2'b00, O_LU,   0, 0, 0);      // 2
        step(0, 2'b00, 0, 5, 5, 0, 2'b10, 2'b00, 2'b00, O_NONE, 1, 1, 0);      // 3
        // x0 is not a hazard
        step(0, 2'b00, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00, O_NONE, 1, 1, 0);      // 4
        // load-use on rs2
        step(0, 2'b00, 1, 7, 3, 7, 2'b11, 2'b00, 2'b00, O_LU,   0, 0, 0);      // 5
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_NONE, 1, 2, 0);      // 6
        // matching rs1 that is not used
        step(0, 2'b00, 1, 9, 9, 0, 2'b00, 2'b00, 2'b00, O_NONE, 1, 2, 0);      // 7
        // branch raised during a 3-cycle Dstall, replayed on cycle 4
        step(0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, O_MEM,  1, 2, 0);      // 8
        step(0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, O_MEM,  0, 3, 0);      // 9
        step(0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, O_MEM,  0, 4, 0);      // 10
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_BR,   1, 5, 0);      // 11
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_NONE, 1, 5, 1);      // 12
        // redirect beats load-use
        step(0, 2'b00, 1, 5, 5, 0, 2'b10, 2'b01, 2'b00, O_JR,   1, 5, 1);      // 13
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, O_BOTH, 1, 5, 2);      // 14
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_NONE, 1, 5, 3);      // 15
        // JALR under Istall, then a branch ORed in while pending
        step(0, 2'b10, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, O_MEM,  0, 5, 3);      // 16
        step(0, 2'b10, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, O_MEM,  0, 6, 3);      // 17
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_BOTH, 1, 7, 3);      // 18
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_NONE, 1, 7, 4);      // 19
        // load-use ignored on the replay cycle
        step(0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, O_MEM,  0, 7, 4);      // 20
        step(0, 2'b00, 1, 5, 5, 0, 2'b10, 2'b00, 2'b00, O_BR,   1, 8, 4);      // 21
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_NONE, 1, 8, 5);      // 22
        // WFI: enter, sleep 10 cycles, wake on irq in the same cycle
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, O_NONE, 0, 8, 5);      // 23
        for (int i = 0; i < 10; i++) begin
            step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_WFI, 1, 32'(8 + i), 5); // 24..33
        end
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, O_NONE, 1, 18, 5);     // 34
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_NONE, 1, 18, 5);     // 35
        // WFI with interrupt already pending does not sleep
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, O_NONE, 0, 18, 5);     // 36
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_NONE, 1, 18, 5);     // 37
        // reset while a branch is pending discards it
        step(0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, O_MEM,  1, 18, 5);     // 38
        step(1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_NONE, 1, 0, 0);      // 39
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_NONE, 1, 0, 0);      // 40
        // stall counter wrap from all-ones
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_NONE, 0, 0, 0);      // 41
        force dut.u_stall_cnt.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_stall_cnt.count_q;
        step(0, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_MEM,  1, 32'hFFFF_FFFF, 0); // 42
        step(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, O_NONE, 1, 0, 0);      // 43
        @(posedge clk);
        drv_done = 1'b1;
    end

    // Monitor: outputs are valid every cycle; pop and compare on the falling edge.
    initial begin
        exp_t e;
        logic [6:0] act;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {pc_hold, ifid_hold, mem_stall, wfi_stall, flush, flush_jalr, idexe_bubble};
                n_cmp++;
                if (act !== e.outs) begin
                    n_bad++;
                    $display("FAIL ctrl[%0d] got %b want %b", e.idx, act, e.outs);
                end
                if (e.chk_cnt) begin
                    n_cmp++;
                    if (stall_cnt !== e.scnt || flush_cnt !== e.fcnt) begin
                        n_bad++;
                        $display("FAIL cnt[%0d] got stall=%0h flush=%0h want stall=%0h flush=%0h",
                                 e.idx, stall_cnt, flush_cnt, e.scnt, e.fcnt);
                    end
                end
            end else if (drv_done) begin
                break;
            end
        end
        if (!drv_done || exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
